// File: rtl/flash_sample_reader.sv
// Streams 16-bit audio samples from a flash song image over Avalon-MM, two samples per fetched word.
// Build option FLASH_WRAP_EN: wrap around at the song ends instead of stopping there.
module flash_sample_reader #(
  parameter int unsigned       ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_read,
  input  logic              dir,
  input  logic              restart,
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       audio_sample,
  output logic              dataReady,
  output logic              readFinish
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQ        = 3'd1,
    WAIT_VALID = 3'd2,
    EMIT1      = 3'd3,
    HOLD       = 3'd4,
    EMIT2      = 3'd5,
    ADVANCE    = 3'd6,
    RESTART    = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       word_r;
  logic              dir_lat_r;
  logic              pending_restart_r;
  logic              stopped_r;

  // The address register drives the bus directly; it only moves outside REQ.
  assign flash_address = addr_r;

  // Playback state machine with registered bus and audio outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= IDLE;
      addr_r            <= START_ADDR;
      word_r            <= 32'h0000_0000;
      dir_lat_r         <= 1'b0;
      pending_restart_r <= 1'b0;
      stopped_r         <= 1'b0;
      flash_read        <= 1'b0;
      audio_sample      <= 16'h0000;
      dataReady         <= 1'b0;
      readFinish        <= 1'b0;
    end else begin
      dataReady  <= 1'b0;
      readFinish <= 1'b0;
      case (state_r)
        IDLE: begin
          if (restart) begin
            state_r    <= RESTART;
            addr_r     <= dir ? END_ADDR : START_ADDR;
            readFinish <= 1'b1;
            stopped_r  <= 1'b0;
          end else if (start_read && sample_tick && !stopped_r) begin
            dir_lat_r  <= dir;
            flash_read <= 1'b1;
            state_r    <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          // A restart here is deferred until the read has completed.
          pending_restart_r <= pending_restart_r | restart;
          if (!flash_waitrequest) begin
            flash_read <= 1'b0;
            state_r    <= WAIT_VALID;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT_VALID: begin
          if (flash_readdatavalid) begin
            word_r <= flash_readdata;
            if (pending_restart_r || restart) begin
              state_r    <= RESTART;
              addr_r     <= dir ? END_ADDR : START_ADDR;
              readFinish <= 1'b1;
              stopped_r  <= 1'b0;
            end else begin
              audio_sample <= dir_lat_r ? flash_readdata[31:16] : flash_readdata[15:0];
              dataReady    <= 1'b1;
              state_r      <= EMIT1;
            end
          end else begin
            pending_restart_r <= pending_restart_r | restart;
          end
        end
        EMIT1: begin
          state_r <= HOLD;
        end
        HOLD: begin
          if (restart) begin
            state_r    <= RESTART;
            addr_r     <= dir ? END_ADDR : START_ADDR;
            readFinish <= 1'b1;
            stopped_r  <= 1'b0;
          end else if (start_read && sample_tick) begin
            audio_sample <= dir_lat_r ? word_r[15:0] : word_r[31:16];
            dataReady    <= 1'b1;
            state_r      <= EMIT2;
          end else begin
            state_r <= HOLD;
          end
        end
        EMIT2: begin
          state_r <= ADVANCE;
        end
        ADVANCE: begin
`ifdef FLASH_WRAP_EN
          if (dir_lat_r) begin
            addr_r <= (addr_r == START_ADDR) ? END_ADDR : addr_r - ADDR_ONE;
          end else begin
            addr_r <= (addr_r == END_ADDR) ? START_ADDR : addr_r + ADDR_ONE;
          end
`else
          // Hitting a song end parks the address and blocks playback until a restart.
          if (dir_lat_r && (addr_r == START_ADDR)) begin
            stopped_r <= 1'b1;
          end else if (!dir_lat_r && (addr_r == END_ADDR)) begin
            stopped_r <= 1'b1;
          end else if (dir_lat_r) begin
            addr_r <= addr_r - ADDR_ONE;
          end else begin
            addr_r <= addr_r + ADDR_ONE;
          end
`endif
          state_r <= IDLE;
        end
        RESTART: begin
          pending_restart_r <= 1'b0;
          state_r           <= IDLE;
        end
        default: begin
          flash_read <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule
